// File: rtl/cpu_pkg.sv
// Shared constants for the execute stage: operand widths, ALU opcodes, FSM states.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH     = 16;
    localparam int unsigned REG_ADDR_WIDTH = 2;
    localparam int unsigned OP_WIDTH       = 3;
    localparam int unsigned CNT_WIDTH      = 4;

    localparam logic [OP_WIDTH-1:0] ALU_ADD   = 3'b000;
    localparam logic [OP_WIDTH-1:0] ALU_SUB   = 3'b001;
    localparam logic [OP_WIDTH-1:0] ALU_AND   = 3'b010;
    localparam logic [OP_WIDTH-1:0] ALU_OR    = 3'b011;
    localparam logic [OP_WIDTH-1:0] ALU_SLT   = 3'b100;
    localparam logic [OP_WIDTH-1:0] ALU_SLL   = 3'b101;
    localparam logic [OP_WIDTH-1:0] ALU_MUL   = 3'b110;
    localparam logic [OP_WIDTH-1:0] ALU_PASSB = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath; one partial product per step, low bits only.
module alu_mul_iter
    import cpu_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_acc_next_c,
    output logic                  o_last_c
);

    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] w_addend;

    assign w_addend     = r_mplier[0] ? r_mcand : '0;
    assign o_acc_next_c = r_acc + w_addend;
    assign o_last_c     = (r_count == CNT_WIDTH'(DATA_WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (i_step) begin
            r_acc    <= o_acc_next_c;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/exec_alu_stage.sv
// Execute stage: single-cycle ALU ops plus a 16-step multiply, with Start/Busy/Done handshake
// and register-file write-back outputs.
module exec_alu_stage
    import cpu_pkg::*;
(
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [OP_WIDTH-1:0]       ALUOp,
    input  logic [DATA_WIDTH-1:0]     OperandA,
    input  logic [DATA_WIDTH-1:0]     OperandB,
    input  logic [REG_ADDR_WIDTH-1:0] DestReg,
    input  logic                      WbEnable,
    output logic                      Busy,
    output logic                      Done,
    output logic                      RegWrite,
    output logic [REG_ADDR_WIDTH-1:0] RD,
    output logic [DATA_WIDTH-1:0]     WriteData,
    output logic                      Zero,
    output logic                      Overflow
);

    state_t                    r_state;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_regwrite;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_zero;
    logic                      r_ovf;
    logic                      r_wb_pend;
    logic [REG_ADDR_WIDTH-1:0] r_rd_pend;

    logic                      w_accept;
    logic                      w_load;
    logic                      w_step;
    logic                      w_last;
    logic [DATA_WIDTH-1:0]     w_acc_next;
    logic [DATA_WIDTH-1:0]     w_sum;
    logic [DATA_WIDTH-1:0]     w_diff;
    logic [DATA_WIDTH-1:0]     w_result;
    logic                      w_ovf;

    assign w_accept = Start && (r_state == S_IDLE);
    assign w_load   = w_accept && (ALUOp == ALU_MUL);
    assign w_step   = (r_state == S_MUL);
    assign w_sum    = OperandA + OperandB;
    assign w_diff   = OperandA - OperandB;

    alu_mul_iter u_mul (
        .i_clk        (Clock),
        .i_rst        (Reset),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_a          (OperandA),
        .i_b          (OperandB),
        .o_acc_next_c (w_acc_next),
        .o_last_c     (w_last)
    );

    // Single-cycle ALU; overflow is the signed-overflow rule for ADD/SUB only
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (ALUOp)
            ALU_ADD: begin
                w_result = w_sum;
                w_ovf    = (OperandA[DATA_WIDTH-1] == OperandB[DATA_WIDTH-1]) &&
                           (w_sum[DATA_WIDTH-1] != OperandA[DATA_WIDTH-1]);
            end
            ALU_SUB: begin
                w_result = w_diff;
                w_ovf    = (OperandA[DATA_WIDTH-1] != OperandB[DATA_WIDTH-1]) &&
                           (w_diff[DATA_WIDTH-1] != OperandA[DATA_WIDTH-1]);
            end
            ALU_AND:   w_result = OperandA & OperandB;
            ALU_OR:    w_result = OperandA | OperandB;
            ALU_SLT:   w_result = DATA_WIDTH'($signed(OperandA) < $signed(OperandB));
            ALU_SLL:   w_result = OperandA << OperandB[CNT_WIDTH-1:0];
            ALU_PASSB: w_result = OperandB;
            default:   w_result = '0;
        endcase
    end

    // Control FSM and output registers; Done/RegWrite default low so they pulse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_wdata    <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_wb_pend  <= 1'b0;
            r_rd_pend  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_regwrite <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state   <= S_MUL;
                        r_busy    <= 1'b1;
                        r_wb_pend <= WbEnable;
                        r_rd_pend <= DestReg;
                    end else if (w_accept) begin
                        r_done     <= 1'b1;
                        r_regwrite <= WbEnable;
                        r_rd       <= DestReg;
                        r_wdata    <= w_result;
                        r_zero     <= (w_result == '0);
                        r_ovf      <= w_ovf;
                    end
                end
                S_MUL: begin
                    if (w_last) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_regwrite <= r_wb_pend;
                        r_rd       <= r_rd_pend;
                        r_wdata    <= w_acc_next;
                        r_zero     <= (w_acc_next == '0);
                        r_ovf      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign RegWrite  = r_regwrite;
    assign RD        = r_rd;
    assign WriteData = r_wdata;
    assign Zero      = r_zero;
    assign Overflow  = r_ovf;

endmodule

// File: tb/tb_exec_alu_stage.sv
// Directed plus randomized bench for exec_alu_stage against an arithmetic reference model.
module tb_exec_alu_stage;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [2:0]  ALUOp;
    logic [15:0] OperandA;
    logic [15:0] OperandB;
    logic [1:0]  DestReg;
    logic        WbEnable;
    logic        Busy;
    logic        Done;
    logic        RegWrite;
    logic [1:0]  RD;
    logic [15:0] WriteData;
    logic        Zero;
    logic        Overflow;

    int total = 0;
    int bad   = 0;

    exec_alu_stage dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .ALUOp     (ALUOp),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .DestReg   (DestReg),
        .WbEnable  (WbEnable),
        .Busy      (Busy),
        .Done      (Done),
        .RegWrite  (RegWrite),
        .RD        (RD),
        .WriteData (WriteData),
        .Zero      (Zero),
        .Overflow  (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns {overflow, result} computed with plain integer arithmetic
    function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        int          sa;
        int          sb;
        int          r;
        longint      p;
        logic [15:0] res;
        logic        ov;
        sa  = $signed(a);
        sb  = $signed(b);
        ov  = 1'b0;
        res = 16'h0000;
        case (op)
            3'd0: begin r = sa + sb; res = 16'(r); ov = (r > 32767) || (r < -32768); end
            3'd1: begin r = sa - sb; res = 16'(r); ov = (r > 32767) || (r < -32768); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = (sa < sb) ? 16'd1 : 16'd0;
            3'd5: res = 16'(int'(a) * (1 << (int'(b) % 16)));
            3'd6: begin p = longint'(a) * longint'(b); res = 16'(p); end
            default: res = b;
        endcase
        return {ov, res};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, optionally poke an ADD Start at cycle poke
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] rd, input logic wb, input int poke, input string tag);
        logic [16:0] e;
        int          lat;
        int          busy_n;
        int          exp_lat;
        e       = model(op, a, b);
        exp_lat = (op == 3'd6) ? 17 : 1;
        @(negedge Clock);
        Start = 1'b1; ALUOp = op; OperandA = a; OperandB = b; DestReg = rd; WbEnable = wb;
        @(negedge Clock);
        Start = 1'b0;
        OperandA = 16'($urandom); OperandB = 16'($urandom);
        DestReg = 2'($urandom); WbEnable = 1'($urandom); ALUOp = 3'($urandom);
        lat = 1;
        busy_n = 0;
        while (!Done && lat < 40) begin
            if (Busy) busy_n++;
            if (lat == poke) begin
                Start = 1'b1; ALUOp = 3'd0; OperandA = 16'($urandom); OperandB = 16'($urandom);
            end else begin
                Start = 1'b0;
            end
            @(negedge Clock);
            lat++;
        end
        Start = 1'b0;
        chk({tag, " done"}, Done, 1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_cycles"}, busy_n, exp_lat - 1);
        chk({tag, " busy_at_done"}, Busy, 0);
        chk({tag, " wdata"}, WriteData, e[15:0]);
        chk({tag, " rd"}, RD, rd);
        chk({tag, " regwrite"}, RegWrite, wb);
        chk({tag, " zero"}, Zero, (e[15:0] == 16'h0000));
        chk({tag, " ovf"}, Overflow, e[16]);
        @(negedge Clock);
        chk({tag, " done_pulse"}, Done, 0);
        chk({tag, " rw_pulse"}, RegWrite, 0);
    endtask

    initial begin
        int          pulses;
        logic [2:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;

        Reset = 1'b1; Start = 1'b0; ALUOp = 3'd0; OperandA = 16'h0; OperandB = 16'h0;
        DestReg = 2'd0; WbEnable = 1'b0;
        repeat (3) @(negedge Clock);
        chk("reset busy", Busy, 0);
        chk("reset done", Done, 0);
        chk("reset regwrite", RegWrite, 0);
        chk("reset rd", RD, 0);
        chk("reset wdata", WriteData, 16'h0000);
        chk("reset zero", Zero, 0);
        chk("reset ovf", Overflow, 0);
        Reset = 1'b0;

        run_op(3'd0, 16'h7FFF, 16'h0001, 2'd2, 1'b1, 0, "add_ovf");

        // Back-to-back: SLT issued in the cycle SUB's Done is high
        @(negedge Clock);
        Start = 1'b1; ALUOp = 3'd1; OperandA = 16'd5; OperandB = 16'd5; DestReg = 2'd1;
        WbEnable = 1'b1;
        @(negedge Clock);
        chk("b2b sub done", Done, 1);
        chk("b2b sub wdata", WriteData, 16'h0000);
        chk("b2b sub zero", Zero, 1);
        ALUOp = 3'd4; OperandA = 16'hFFFF; OperandB = 16'h0001; DestReg = 2'd3;
        @(negedge Clock);
        Start = 1'b0;
        chk("b2b slt done", Done, 1);
        chk("b2b slt wdata", WriteData, 16'h0001);
        chk("b2b slt zero", Zero, 0);
        chk("b2b slt rd", RD, 2'd3);
        @(negedge Clock);
        chk("b2b done_pulse", Done, 0);

        run_op(3'd6, 16'h1234, 16'h0010, 2'd1, 1'b1, 0, "mul_1234");
        run_op(3'd6, 16'd300, 16'd200, 2'd3, 1'b1, 0, "mul_300x200");
        run_op(3'd6, 16'h0ABC, 16'h0123, 2'd0, 1'b1, 5, "mul_poke");
        run_op(3'd5, 16'h0001, 16'hFFF4, 2'd2, 1'b0, 0, "sll_nowb");

        // Reset in the middle of a multiply aborts it silently
        @(negedge Clock);
        Start = 1'b1; ALUOp = 3'd6; OperandA = 16'h00FF; OperandB = 16'h0101;
        DestReg = 2'd3; WbEnable = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (7) @(negedge Clock);
        chk("abort busy_before", Busy, 1);
        Reset = 1'b1;
        @(negedge Clock);
        chk("abort busy", Busy, 0);
        chk("abort done", Done, 0);
        chk("abort wdata", WriteData, 16'h0000);
        chk("abort regwrite", RegWrite, 0);
        Reset = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(negedge Clock);
            if (Done || RegWrite) pulses++;
        end
        chk("abort no_done", pulses, 0);

        repeat (30) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            run_op(rop, ra, rb, 2'($urandom), 1'($urandom), 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
